// File: rtl/parity_frame_checker_if.sv
// Bit-stream and result handshake bundle for parity_frame_checker.
// The master drives serial bits and consumes results; the slave is the checker.
interface parity_frame_checker_if #(
  parameter int ERR_W = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_parity;
  logic             res_error;
  logic [ERR_W-1:0] err_count;
  logic             clr_count;

  modport master (
    output bit_in, bit_valid, res_ready, clr_count,
    input  bit_ready, res_valid, res_parity, res_error, err_count
  );

  modport slave (
    input  bit_in, bit_valid, res_ready, clr_count,
    output bit_ready, res_valid, res_parity, res_error, err_count
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial parity checker: folds FRAME_LEN data bits into an XOR accumulator,
// compares against the trailing parity bit and reports through a valid/ready result.
module parity_frame_checker #(
  parameter int FRAME_LEN  = 8,
  parameter int ODD_PARITY = 0,
  parameter int ERR_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  parity_frame_checker_if.slave  bus
);

  localparam int   CNT_W = 8;
  localparam logic ODD   = 1'(ODD_PARITY);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {COLLECT, CHECK, REPORT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             res_valid_q, res_valid_d;
  logic             res_parity_q, res_parity_d;
  logic             res_error_q, res_error_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             accept;
  logic             err_term;
  logic             err_inc;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign bus.bit_ready  = (state_q != REPORT);
  assign bus.res_valid  = res_valid_q;
  assign bus.res_parity = res_parity_q;
  assign bus.res_error  = res_error_q;
  assign bus.err_count  = err_q;

  assign accept   = bus.bit_valid & bus.bit_ready;
  assign err_term = acc_q ^ bus.bit_in ^ ODD;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    res_valid_d  = res_valid_q;
    res_parity_d = res_parity_q;
    res_error_d  = res_error_q;
    err_inc      = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          acc_d = acc_q ^ bus.bit_in;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CHECK: begin
        if (accept) begin
          res_parity_d = acc_q ^ ODD;
          res_error_d  = err_term;
          res_valid_d  = 1'b1;
          acc_d        = 1'b0;
          err_inc      = err_term;
          state_d      = REPORT;
        end
      end
      REPORT: begin
        // Outputs stay frozen until the consumer takes the result.
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // A clear coinciding with an errored frame leaves the counter at zero.
    if (bus.clr_count)  err_d = '0;
    else if (err_inc)   err_d = sat_inc(err_q);
    else                err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_error_q  <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      res_valid_q  <= res_valid_d;
      res_parity_q <= res_parity_d;
      res_error_q  <= res_error_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker across four parameter sets sharing one stimulus bus.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       clr_count = 1'b0;
  logic [1:0] sel = 2'd0;

  logic       o_ready, o_valid, o_par, o_err;
  logic [7:0] o_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // 0: FL=8 even ERR_W=8, 1: FL=8 odd, 2: FL=8 even ERR_W=2, 3: FL=1 even
  parity_frame_checker_if #(.ERR_W(8)) i0 ();
  parity_frame_checker_if #(.ERR_W(8)) i1 ();
  parity_frame_checker_if #(.ERR_W(2)) i2 ();
  parity_frame_checker_if #(.ERR_W(8)) i3 ();

  parity_frame_checker #(.FRAME_LEN(8), .ODD_PARITY(0), .ERR_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  parity_frame_checker #(.FRAME_LEN(8), .ODD_PARITY(1), .ERR_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  parity_frame_checker #(.FRAME_LEN(8), .ODD_PARITY(0), .ERR_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  parity_frame_checker #(.FRAME_LEN(1), .ODD_PARITY(0), .ERR_W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3));

  assign i0.bit_in = bit_in; assign i0.bit_valid = bit_valid && sel == 2'd0;
  assign i0.res_ready = res_ready && sel == 2'd0; assign i0.clr_count = clr_count && sel == 2'd0;
  assign i1.bit_in = bit_in; assign i1.bit_valid = bit_valid && sel == 2'd1;
  assign i1.res_ready = res_ready && sel == 2'd1; assign i1.clr_count = clr_count && sel == 2'd1;
  assign i2.bit_in = bit_in; assign i2.bit_valid = bit_valid && sel == 2'd2;
  assign i2.res_ready = res_ready && sel == 2'd2; assign i2.clr_count = clr_count && sel == 2'd2;
  assign i3.bit_in = bit_in; assign i3.bit_valid = bit_valid && sel == 2'd3;
  assign i3.res_ready = res_ready && sel == 2'd3; assign i3.clr_count = clr_count && sel == 2'd3;

  always_comb begin
    o_ready = i0.bit_ready; o_valid = i0.res_valid; o_par = i0.res_parity;
    o_err = i0.res_error; o_cnt = i0.err_count;
    case (sel)
      2'd1: begin
        o_ready = i1.bit_ready; o_valid = i1.res_valid; o_par = i1.res_parity;
        o_err = i1.res_error; o_cnt = i1.err_count;
      end
      2'd2: begin
        o_ready = i2.bit_ready; o_valid = i2.res_valid; o_par = i2.res_parity;
        o_err = i2.res_error; o_cnt = {6'b0, i2.err_count};
      end
      2'd3: begin
        o_ready = i3.bit_ready; o_valid = i3.res_valid; o_par = i3.res_parity;
        o_err = i3.res_error; o_cnt = i3.err_count;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the bit until the selected checker is ready, then lets one edge accept it.
  task automatic send_bit(input logic b);
    int guard = 0;
    bit_in = b;
    bit_valid = 1'b1;
    while (!o_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!o_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_bit_timeout sel=%0d bit_ready stuck at %b, needed 1", sel, o_ready);
    end
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[i]);
  endtask

  task automatic select(input logic [1:0] s);
    bit_valid = 1'b0;
    sel = s;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      select(2'(s));
      vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready sel=%0d got %b exp 1", s, o_ready); end
      vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid sel=%0d got %b exp 0", s, o_valid); end
      vectors++; if (o_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt sel=%0d got %0d exp 0", s, o_cnt); end
      vectors++; if (o_par !== 1'b0 || o_err !== 1'b0) begin miscompares++; $display("FAIL reset_res sel=%0d got par=%b err=%b exp 0 0", s, o_par, o_err); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_even_ok();
    select(2'd0);
    res_ready = 1'b1;
    send_data(8'h0D, 8);
    send_bit(1'b1);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL even_ok_valid got %b exp 1", o_valid); end
    vectors++; if (o_par !== 1'b1) begin miscompares++; $display("FAIL even_ok_par got %b exp 1", o_par); end
    vectors++; if (o_err !== 1'b0) begin miscompares++; $display("FAIL even_ok_err got %b exp 0", o_err); end
    vectors++; if (o_cnt !== 8'd0) begin miscompares++; $display("FAIL even_ok_cnt got %0d exp 0", o_cnt); end
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL even_ok_ready_hs got %b exp 0", o_ready); end
    tick();
    vectors++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin miscompares++; $display("FAIL even_ok_after_hs got valid=%b ready=%b exp 0 1", o_valid, o_ready); end
  endtask

  task automatic test_even_err_stall();
    select(2'd0);
    res_ready = 1'b0;
    send_data(8'h0D, 8);
    send_bit(1'b0);
    vectors++; if (o_valid !== 1'b1 || o_par !== 1'b1 || o_err !== 1'b1) begin miscompares++; $display("FAIL even_err_res got v=%b p=%b e=%b exp 1 1 1", o_valid, o_par, o_err); end
    vectors++; if (o_cnt !== 8'd1) begin miscompares++; $display("FAIL even_err_cnt got %0d exp 1", o_cnt); end
    bit_in = 1'b1;
    bit_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin miscompares++; $display("FAIL stall_hs cyc=%0d got v=%b r=%b exp 1 0", k, o_valid, o_ready); end
      vectors++; if (o_par !== 1'b1 || o_err !== 1'b1 || o_cnt !== 8'd1) begin miscompares++; $display("FAIL stall_hold cyc=%0d got p=%b e=%b c=%0d exp 1 1 1", k, o_par, o_err, o_cnt); end
    end
    bit_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    vectors++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release got v=%b r=%b exp 0 1", o_valid, o_ready); end
    send_data(8'h0D, 8);
    send_bit(1'b1);
    vectors++; if (o_valid !== 1'b1 || o_err !== 1'b0 || o_cnt !== 8'd1) begin miscompares++; $display("FAIL stall_ignored got v=%b e=%b c=%0d exp 1 0 1", o_valid, o_err, o_cnt); end
    tick();
  endtask

  task automatic test_odd();
    select(2'd1);
    res_ready = 1'b1;
    send_data(8'h00, 8);
    send_bit(1'b1);
    vectors++; if (o_valid !== 1'b1 || o_par !== 1'b1 || o_err !== 1'b0) begin miscompares++; $display("FAIL odd_ok got v=%b p=%b e=%b exp 1 1 0", o_valid, o_par, o_err); end
    send_data(8'h00, 8);
    send_bit(1'b0);
    vectors++; if (o_valid !== 1'b1 || o_par !== 1'b1 || o_err !== 1'b1) begin miscompares++; $display("FAIL odd_err got v=%b p=%b e=%b exp 1 1 1", o_valid, o_par, o_err); end
    vectors++; if (o_cnt !== 8'd1) begin miscompares++; $display("FAIL odd_cnt got %0d exp 1", o_cnt); end
    tick();
  endtask

  task automatic test_bubbles_reset();
    logic [8:0] pat;
    select(2'd0);
    res_ready = 1'b1;
    pat = 9'h10D;
    for (int i = 0; i < 9; i++) begin
      send_bit(pat[i]);
      bit_in = ~pat[i];
      tick();
    end
    // The parity accept was followed by one bubble, which was also the handshake cycle.
    vectors++; if (o_valid !== 1'b0 || o_par !== 1'b1 || o_err !== 1'b0 || o_cnt !== 8'd1) begin miscompares++; $display("FAIL bubbles got v=%b p=%b e=%b c=%0d exp 0 1 0 1", o_valid, o_par, o_err, o_cnt); end
    send_data(8'h07, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_cnt !== 8'd0) begin miscompares++; $display("FAIL midreset got r=%b v=%b c=%0d exp 1 0 0", o_ready, o_valid, o_cnt); end
    send_data(8'h0D, 8);
    send_bit(1'b1);
    vectors++; if (o_valid !== 1'b1 || o_par !== 1'b1 || o_err !== 1'b0 || o_cnt !== 8'd0) begin miscompares++; $display("FAIL post_reset got v=%b p=%b e=%b c=%0d exp 1 1 0 0", o_valid, o_par, o_err, o_cnt); end
    tick();
  endtask

  task automatic test_saturation();
    logic [7:0] exp_cnt [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    select(2'd2);
    res_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      send_data(8'h0D, 8);
      send_bit(1'b0);
      vectors++; if (o_err !== 1'b1 || o_cnt !== exp_cnt[f]) begin miscompares++; $display("FAIL sat frame=%0d got e=%b c=%0d exp 1 %0d", f, o_err, o_cnt, exp_cnt[f]); end
    end
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    vectors++; if (o_cnt !== 8'd0) begin miscompares++; $display("FAIL clr got %0d exp 0", o_cnt); end
    send_data(8'h0D, 8);
    send_bit(1'b0);
    vectors++; if (o_cnt !== 8'd1) begin miscompares++; $display("FAIL sat_restart got %0d exp 1", o_cnt); end
    send_data(8'h0D, 8);
    clr_count = 1'b1;
    send_bit(1'b0);
    clr_count = 1'b0;
    vectors++; if (o_err !== 1'b1 || o_cnt !== 8'd0) begin miscompares++; $display("FAIL clr_vs_inc got e=%b c=%0d exp 1 0", o_err, o_cnt); end
    tick();
  endtask

  task automatic test_back_to_back_len1();
    int t1 = -1;
    int t2 = -1;
    select(2'd3);
    res_ready = 1'b1;
    bit_in = 1'b1;
    bit_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_valid === 1'b1) begin
        vectors++; if (o_par !== 1'b1 || o_err !== 1'b0) begin miscompares++; $display("FAIL len1_res cyc=%0d got p=%b e=%b exp 1 0", c, o_par, o_err); end
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    bit_valid = 1'b0;
    vectors++; if (t1 !== 1) begin miscompares++; $display("FAIL len1_first got cyc %0d exp 1", t1); end
    vectors++; if (t2 - t1 !== 3) begin miscompares++; $display("FAIL len1_spacing got %0d exp 3", t2 - t1); end
  endtask

  initial begin
    test_reset();
    test_even_ok();
    test_even_err_stall();
    test_odd();
    test_bubbles_reset();
    test_saturation();
    test_back_to_back_len1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Serial parity stage placed directly downstream of the XOR/XNOR gate cell. It consumes a bit stream one bit per accepted beat and folds it into a running XOR accumulator. Each frame is FRAME_LEN data bits followed by one received parity bit. The block then reports the generated parity, a parity-error flag and a saturating error count through a valid/ready result handshake.

Parameters:
FRAME_LEN, 8, data bits per frame; legal range 1..255.
ODD_PARITY, 0, 0 = even parity, 1 = odd parity.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
bit_in  input  1  serial data bit or parity bit.
bit_valid  input  1  bit_in is valid this cycle.
bit_ready  output  1  block accepts bit_in this cycle.
res_valid  output  1  frame result available.
res_ready  input  1  consumer takes the result this cycle.
res_parity  output  1  generated parity of the frame data bits (acc ^ ODD_PARITY).
res_error  output  1  received parity bit mismatched the generated parity.
err_count  output  ERR_W  number of errored frames, saturating.
clr_count  input  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=COLLECT; bit counter=0; acc=0; res_valid=0; res_parity=0; res_error=0; err_count=0. Reset wins over every other input, including mid-frame and while a result is pending. Any partial frame is discarded.
- Accept rule: a bit is accepted in a cycle only when bit_valid=1 and bit_ready=1. bit_ready is a pure function of state: 1 in COLLECT and CHECK, 0 in REPORT.
- FSM states: COLLECT, CHECK, REPORT.
- COLLECT:
  - On each accepted bit: acc <= acc ^ bit_in; counter increments.
  - On the accept with counter==FRAME_LEN-1: counter <= 0 and state goes to CHECK.
  - With FRAME_LEN=1, the single data bit moves the FSM to CHECK immediately.
- CHECK:
  - On the accepted parity bit p: res_parity <= acc ^ ODD_PARITY; res_error <= acc ^ p ^ ODD_PARITY; res_valid <= 1; acc <= 0; state goes to REPORT.
  - If that error term is 1, err_count increments, saturating at 2^ERR_W-1.
- REPORT:
  - res_valid=1. res_parity and res_error are held stable until the handshake completes.
  - On res_ready=1: res_valid <= 0 and state goes to COLLECT. bit_ready therefore rises the cycle after the handshake.
  - No bit is accepted in the handshake cycle.
- Latency: result is visible the cycle after the parity bit is accepted. Minimum frame period is FRAME_LEN+2 cycles.
- bit_valid=0 cycles (bubbles) in COLLECT or CHECK leave all state unchanged.
- clr_count=1 sets err_count to 0 next cycle. If it coincides with an increment, the clear wins and the result is 0.
- res_parity and res_error hold their last values after res_valid drops. They are meaningful only while res_valid=1.
- All outputs are registered except bit_ready, which is decoded from the state register.

Test Plan:
- Even parity, FRAME_LEN=8: data 1,0,1,1,0,0,0,0 (three ones) then parity bit 1, res_ready held 1 -> one cycle after the parity accept: res_valid=1, res_parity=1, res_error=0, err_count=0. Next frame is accepted 2 cycles later.
- Even parity: same data, parity bit 0 -> res_error=1, err_count=1. With res_ready held 0 for 5 cycles: res_valid stays 1, bit_ready stays 0, outputs stay stable, and bits driven during those cycles are ignored.
- ODD_PARITY=1, data all zeros, parity bit 1 -> res_parity=1, res_error=0. Same frame with parity bit 0 -> res_error=1.
- Bubbles and reset: alternate bit_valid 1/0 through a frame and check the result equals the gap-free case. Assert rst_n=0 after 4 data bits -> bit_ready=1, res_valid=0, err_count=0. A fresh 8-bit frame is then decoded correctly, proving the partial frame was dropped.
- Saturation with ERR_W=2: send 5 errored frames -> err_count reads 1,2,3,3,3. Assert clr_count in the same cycle as an increment -> err_count=0.
- FRAME_LEN=1: data bit 1 then parity bit 1, even parity -> res_parity=1, res_error=0. Two consecutive frames complete with exactly 3 cycles between results when res_ready is held 1.
